// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a program into the core's instruction memory over a
// valid/ready word stream, then releases the core's active-low reset after a
// fixed settle delay. The core is held in reset whenever memory is being written.
//
// Handshake: a word transfers on a rising edge where s_valid and s_ready are both
// high; s_ready is registered and only asserted in LOAD while words remain, and
// the producer may hold s_valid low for any number of cycles without penalty.
module imem_boot_loader #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int MAX_WORDS     = 32,
    parameter int RELEASE_DELAY = 4,
    localparam int LEN_WIDTH    = $clog2(MAX_WORDS) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  prog_len,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] imem_din,
    output logic                  imem_web,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic                  core_rstn,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            dbg_state
);

    localparam int CNT_WIDTH = $clog2(RELEASE_DELAY) + 1;
    localparam logic [LEN_WIDTH-1:0] MAX_LEN  = LEN_WIDTH'(MAX_WORDS);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(RELEASE_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] len;
    logic [LEN_WIDTH-1:0] idx;
    logic [CNT_WIDTH-1:0] cnt;

    assign dbg_state = state;

    // Boot sequencer: start decision, word writes, settle countdown, core release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            len       <= '0;
            idx       <= '0;
            cnt       <= '0;
            s_ready   <= 1'b0;
            imem_din  <= '0;
            imem_web  <= 1'b1;
            imem_addr <= '0;
            core_rstn <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse; only a handshake re-asserts it.
            imem_web <= 1'b1;
            case (state)
                IDLE, RUN: begin
                    // The cycle after entering RUN releases the core; this extra
                    // cycle makes release land RELEASE_DELAY+1 edges after capture.
                    if (state == RUN) begin
                        core_rstn <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end
                    if (start) begin
                        core_rstn <= 1'b0;
                        done      <= 1'b0;
                        if (prog_len > MAX_LEN) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else if (prog_len == '0) begin
                            error <= 1'b0;
                            busy  <= 1'b1;
                            cnt   <= CNT_INIT;
                            state <= SETTLE;
                        end else begin
                            error   <= 1'b0;
                            busy    <= 1'b1;
                            len     <= prog_len;
                            idx     <= '0;
                            s_ready <= 1'b1;
                            state   <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (s_valid && s_ready) begin
                        imem_web  <= 1'b0;
                        imem_din  <= s_data;
                        imem_addr <= ADDR_WIDTH'({idx, 2'b00});
                        idx       <= idx + LEN_ONE;
                        if (idx == len - LEN_ONE) begin
                            s_ready <= 1'b0;
                            cnt     <= CNT_INIT;
                            state   <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state <= RUN;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed sequence with randomized words and stall patterns,
// checked against a write/release model derived from the boot loader's rules.
module tb_imem_boot_loader;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MW = 32;
    localparam int RD = 4;
    localparam int LW = $clog2(MW) + 1;

    // clock / reset block
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] prog_len = '0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic [DW-1:0] imem_din;
    logic          imem_web;
    logic [AW-1:0] imem_addr;
    logic          core_rstn;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    imem_boot_loader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WORDS(MW), .RELEASE_DELAY(RD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .prog_len(prog_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .imem_din(imem_din), .imem_web(imem_web), .imem_addr(imem_addr),
        .core_rstn(core_rstn), .busy(busy), .done(done), .error(error),
        .dbg_state(dbg_state)
    );

    // scoreboard state
    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_data_q[$];
    int            exp_cyc_q[$];
    logic [AW-1:0] obs_addr_q[$];
    logic [DW-1:0] obs_data_q[$];
    int            obs_cyc_q[$];
    logic [DW-1:0] prog[MW];
    int            n_tests = 0;
    int            n_fail = 0;
    int            start_cyc = 0;
    int            wr_while_running = 0;
    int            wr_in_rst = 0;

    // write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (imem_web === 1'b0) begin
            obs_addr_q.push_back(imem_addr);
            obs_data_q.push_back(imem_din);
            obs_cyc_q.push_back(cyc);
            if (core_rstn !== 1'b0) wr_while_running++;
            if (rst) wr_in_rst++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        exp_addr_q.delete(); exp_data_q.delete(); exp_cyc_q.delete();
        obs_addr_q.delete(); obs_data_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {26'd0, s_ready, imem_web, core_rstn, busy, done, error}, 32'b010000);
        check({tag, "_din"}, imem_din, 32'd0);
        check({tag, "_addr"}, imem_addr, 32'd0);
    endtask

    task automatic fill_prog(input int len);
        for (int i = 0; i < MW; i++) prog[i] = DW'($urandom);
        if (len == 21) begin
            prog[0]  = 32'h00500113;
            prog[20] = 32'h00210063;
        end
    endtask

    // driver: pulse start then stream words; mode 0 always valid, 1 toggle, 2 random
    task automatic load(input int len, input int mode, input int abort_after);
        int  k = 0;
        int  t = 0;
        int  guard = 0;
        logic hs;
        clear_queues();
        start = 1'b1;
        prog_len = LW'(len);
        s_valid = (mode == 0);
        s_data = prog[0];
        step();
        start_cyc = cyc;
        start = 1'b0;
        check("rstn_low_after_start", {31'd0, core_rstn}, 32'd0);
        while (k < len && guard < 400 && !(abort_after > 0 && k == abort_after)) begin
            case (mode)
                0: s_valid = 1'b1;
                1: s_valid = (t % 2 == 0);
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            t++;
            s_data = s_valid ? prog[k] : DW'($urandom);
            hs = s_valid && s_ready;
            step();
            guard++;
            if (hs) begin
                exp_addr_q.push_back(AW'(4 * k));
                exp_data_q.push_back(prog[k]);
                exp_cyc_q.push_back(cyc);
                k++;
            end
        end
        s_valid = 1'b0;
        if (abort_after == 0) begin
            check("accepted_words", k, len);
            check("s_ready_after_last", {31'd0, s_ready}, 32'd0);
            check("busy_in_settle", {31'd0, busy}, 32'd1);
        end
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_count"}, obs_addr_q.size(), exp_addr_q.size());
        for (int i = 0; i < exp_addr_q.size() && i < obs_addr_q.size(); i++) begin
            check({tag, "_addr"}, obs_addr_q[i], exp_addr_q[i]);
            check({tag, "_data"}, obs_data_q[i], exp_data_q[i]);
            check({tag, "_cycle"}, obs_cyc_q[i], exp_cyc_q[i]);
        end
    endtask

    // release must land RD+1 edges after the reference capture edge
    task automatic wait_release(input string tag, input int ref_cyc);
        int g = 0;
        while (core_rstn !== 1'b1 && g < 100) begin
            step();
            g++;
        end
        check({tag, "_seen"}, {31'd0, core_rstn}, 32'd1);
        check({tag, "_delay"}, cyc - ref_cyc, RD + 1);
        check({tag, "_done_busy"}, {30'd0, done, busy}, 32'b10);
    endtask

    initial begin
        // reset held with random inputs
        for (int i = 0; i < 16; i++) begin
            start = 1'($urandom_range(0, 1));
            prog_len = LW'($urandom_range(0, 40));
            s_valid = 1'($urandom_range(0, 1));
            s_data = DW'($urandom);
            step();
            check_reset_outputs("reset_hold");
        end
        start = 1'b0;
        s_valid = 1'b0;
        rst = 1'b0;
        step();
        step();
        check_reset_outputs("after_reset");

        // 21-word program, valid held high
        fill_prog(21);
        load(21, 0, 0);
        wait_release("full_rate_release", exp_cyc_q[$]);
        check_writes("full_rate");

        // same program, valid toggling
        load(21, 1, 0);
        wait_release("toggle_release", exp_cyc_q[$]);
        check_writes("toggle");

        // oversize length from RUN: error, core held, no writes
        clear_queues();
        start = 1'b1;
        prog_len = LW'(33);
        step();
        start = 1'b0;
        check("err_set", {31'd0, error}, 32'd1);
        check("err_rstn", {30'd0, core_rstn, done}, 32'd0);
        for (int i = 0; i < 5; i++) step();
        check("err_no_writes", obs_addr_q.size(), 0);
        check("err_idle_ctl", {29'd0, core_rstn, s_ready, busy}, 32'd0);
        check("err_sticky", {31'd0, error}, 32'd1);

        // zero length clears error and releases after the delay
        load(0, 0, 0);
        check("err_cleared", {31'd0, error}, 32'd0);
        wait_release("zero_len_release", start_cyc);
        check("zero_len_no_writes", obs_addr_q.size(), 0);

        // restart from RUN with a two-word program
        prog[0] = 32'h00000293;
        prog[1] = 32'h00100113;
        load(2, 0, 0);
        wait_release("restart_release", exp_cyc_q[$]);
        check_writes("restart");

        // random lengths and stall patterns, including full capacity
        for (int r = 0; r < 4; r++) begin
            int len;
            len = (r == 0) ? MW : $urandom_range(1, MW);
            fill_prog(len);
            load(len, 2, 0);
            wait_release("rand_release", exp_cyc_q[$]);
            check_writes("rand");
        end

        // reset after word 10 of a 21-word load
        fill_prog(21);
        load(21, 0, 10);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("abort_reset");
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data = DW'($urandom);
            step();
            check_reset_outputs("abort_hold");
        end
        rst = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) step();
        s_valid = 1'b0;
        check_writes("abort_partial");
        check("abort_rstn_low", {30'd0, core_rstn, s_ready}, 32'd0);
        check("abort_state_idle", {30'd0, busy, done}, 32'd0);

        // a fresh load after the abort completes normally
        load(21, 2, 0);
        wait_release("post_abort_release", exp_cyc_q[$]);
        check_writes("post_abort");

        check("no_write_while_running", wr_while_running, 0);
        check("no_write_in_reset", wr_in_rst, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot sequencer for the RISC-V core's instruction memory. Accepts a program as a valid/ready word stream, writes it word-by-word through the memory's active-low write port at consecutive byte addresses, then releases the core's active-low reset after a fixed settle delay. Sits between the host/debug link and the `imem_din`/`imem_web`/`imem_addr` and `rstn` inputs of the core top. It replaces hand-timed instruction pokes with a deterministic handshake.

## Interface
Parameters:
- `DATA_WIDTH`, 32, instruction word width
- `ADDR_WIDTH`, 32, byte-address width of `imem_addr`
- `MAX_WORDS`, 32, instruction memory capacity in words
- `RELEASE_DELAY`, 4, cycles `core_rstn` stays low after the last write (≥1)

Ports:
- `clk`  in  1  single clock, all logic rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse, begins a load of `prog_len` words
- `prog_len`  in  $clog2(MAX_WORDS)+1  word count, sampled on `start`
- `s_valid`  in  1  program word valid
- `s_data`  in  DATA_WIDTH  program word
- `s_ready`  out  1  loader accepts `s_data` this cycle
- `imem_din`  out  DATA_WIDTH  write data to instruction memory
- `imem_web`  out  1  write enable, active-low
- `imem_addr`  out  ADDR_WIDTH  byte address, word-aligned
- `core_rstn`  out  1  core reset, active-low
- `busy`  out  1  high in LOAD or SETTLE
- `done`  out  1  high while in RUN
- `error`  out  1  sticky: `prog_len` > `MAX_WORDS` on last `start`

## Operation
- States: IDLE, LOAD, SETTLE, RUN.
- IDLE: `core_rstn`=0, `s_ready`=0. On `start`: if `prog_len` > `MAX_WORDS`, set `error`, stay IDLE. If `prog_len`=0, clear `error`, go to SETTLE. Otherwise clear `error`, latch length, clear word index, go to LOAD.
- LOAD: `s_ready`=1 while index < length. Each handshake (`s_valid` & `s_ready`) registers one write and increments index. After the handshake of word length−1, go to SETTLE. `s_valid` low stalls indefinitely with no write.
- Write address = 4 × index, zero-extended to `ADDR_WIDTH`. Index width is `$clog2(MAX_WORDS)+1`; no wrap is possible because length ≤ `MAX_WORDS`.
- SETTLE: counter loads `RELEASE_DELAY`−1 on entry and counts down. At 0, go to RUN.
- RUN: `core_rstn`=1, `done`=1. A `start` in RUN drives `core_rstn`=0 in the next cycle and re-enters the IDLE decision for that `start` (LOAD/SETTLE/IDLE+error). The core is never running while memory is written.
- `start` in LOAD or SETTLE is ignored.
- `rst` mid-operation aborts immediately: all outputs go to reset values and the partial program stays in memory. A new `start` is required.

## Timing
- Reset values: `s_ready`=0, `imem_din`=0, `imem_web`=1, `imem_addr`=0, `core_rstn`=0, `busy`=0, `done`=0, `error`=0, state IDLE.
- All outputs are registered.
- Write latency: a handshake at edge N gives `imem_web`=0, `imem_din`=word, `imem_addr`=4×idx during cycle N+1, for exactly one cycle. In the cycle after any non-handshake, `imem_web`=1. `imem_din`/`imem_addr` hold their last values.
- Throughput: one word per cycle with `s_valid` held high. `s_ready` drops in the cycle after the final handshake.
- Release: `core_rstn` rises `RELEASE_DELAY`+1 cycles after the edge that captured the last word, i.e. `RELEASE_DELAY` cycles after the final `imem_web` low cycle. `done` rises with it.
- `prog_len`=0: `core_rstn` rises `RELEASE_DELAY`+1 cycles after `start`.
- `error` sets one cycle after the offending `start` and holds until the next legal `start` or `rst`.

## Test plan
- Reset: hold `rst`=1 with random inputs. All outputs must stay at reset values, and `imem_web` must never be 0.
- 21-word program (first word 32'h00500113, last 32'h00210063), `s_valid` always 1, then `start` with `prog_len`=21. Expect 21 consecutive `imem_web`=0 cycles at addresses 0,4,…,80 with matching data. `core_rstn` rises exactly 4 cycles after the last write.
- Same program with `s_valid` toggling 1,0,1,0. Expect exactly 21 writes, no duplicated or skipped addresses, and no `imem_web`=0 on stall cycles.
- `prog_len`=33 → `error`=1, no writes, `core_rstn`=0. Then `prog_len`=0 → `error` clears and `core_rstn` rises 5 cycles after `start`.
- In RUN, pulse `start` with `prog_len`=2 and words 32'h00000293, 32'h00100113. Expect `core_rstn`=0 the next cycle, writes to addresses 0 and 4, then re-release.
- Assert `rst` after word 10 of a 21-word load. Outputs return to reset values, no further writes occur, and `core_rstn` stays 0 until a new `start` completes.
